// File: rtl/store_merge_unit.sv
// store_merge_unit
//
// Performs sb/sh/sw/sd stores against a 64-bit doubleword data memory.
// An sd store is written straight through. A narrower store reads the
// containing doubleword, merges the new bytes at the byte offset, and
// writes the merged word back. A control unit talks to the block through
// a START/DONE handshake.
//
// Parameter:
//   MEM_RD_LAT  cycles from the MEM_RD cycle to valid MEM_RDATA (1..4)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   START       request pulse, only looked at in IDLE
//   STORE_TYPE  00 sb, 01 sh, 10 sw, 11 sd
//   ADDR        byte address of the store
//   STORE_DATA  rs2 value; only the low store-width bytes are used
//   MEM_ADDR    doubleword-aligned address, 0 in IDLE
//   MEM_RD      one-cycle read strobe
//   MEM_WR      one-cycle write strobe
//   MEM_WDATA   merged doubleword, 0 outside WRITE
//   MEM_RDATA   memory read data
//   BUSY        high in every state except IDLE
//   DONE        one-cycle completion pulse
//   MISALIGN    valid with DONE
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   Defined:   misaligned sh/sw/sd complete at once with MISALIGN=1 and no
//              memory access.
//   Undefined: MISALIGN is tied 0 and the low address bits are truncated
//              to the natural alignment of the store width.

module store_merge_unit #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        START,
  input  logic [1:0]  STORE_TYPE,
  input  logic [63:0] ADDR,
  input  logic [63:0] STORE_DATA,
  output logic [63:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [63:0] MEM_WDATA,
  input  logic [63:0] MEM_RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        MISALIGN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_RD_LAT - 1);

  state_e      state_q;
  logic [63:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [63:0] mem_wdata_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  cnt_q;
  logic [63:0] sdata_q;
  logic [7:0]  be_q;

  logic [2:0]  off_d;
  logic [7:0]  be_base;
  logic [7:0]  be_d;
  logic [63:0] sdata_d;
  logic [63:0] byte_mask;
  logic [63:0] merge_d;
  logic        misalign_d;

  // The store data is pre-shifted into its byte lanes at START, together
  // with a byte-enable mask, so the merge after the read is a plain mux.
  // Truncating the offset to the store width gives natural alignment;
  // with the trap enabled, misaligned stores never reach the merge.
  always_comb begin
    off_d   = 3'b000;
    be_base = 8'h00;
    case (STORE_TYPE)
      2'b00: begin
        off_d   = ADDR[2:0];
        be_base = 8'h01;
      end
      2'b01: begin
        off_d   = {ADDR[2:1], 1'b0};
        be_base = 8'h03;
      end
      2'b10: begin
        off_d   = {ADDR[2], 2'b00};
        be_base = 8'h0F;
      end
      default: begin
        off_d   = 3'b000;
        be_base = 8'hFF;
      end
    endcase
    be_d    = be_base << off_d;
    sdata_d = STORE_DATA << {off_d, 3'b000};
  end

  // Enabled bytes come from the new data, all others from the read word.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 8; i++) begin
      byte_mask[8*i +: 8] = {8{be_q[i]}};
    end
    merge_d = (sdata_q & byte_mask) | (MEM_RDATA & ~byte_mask);
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_q;

  always_comb begin
    case (STORE_TYPE)
      2'b01:   misalign_d = ADDR[0];
      2'b10:   misalign_d = |ADDR[1:0];
      2'b11:   misalign_d = |ADDR[2:0];
      default: misalign_d = 1'b0;
    endcase
  end

  assign MISALIGN = misalign_q;
`else
  assign misalign_d = 1'b0;
  assign MISALIGN   = 1'b0;
`endif

  // Single FSM register block. Every output is a register that is loaded
  // on the edge entering the state it belongs to, so the strobes line up
  // exactly with the state. One-cycle strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      sdata_q     <= '0;
      be_q        <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (START) begin
            mem_addr_q <= {ADDR[63:3], 3'b000};
            sdata_q    <= sdata_d;
            be_q       <= be_d;
            busy_q     <= 1'b1;
            if (misalign_d) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
            end else if (STORE_TYPE == 2'b11) begin
              state_q     <= S_WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= STORE_DATA;
            end else begin
              state_q  <= S_READ;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          // Read data is valid in the last wait cycle and is merged
          // straight into the write-data register.
          if (cnt_q == LAST_WAIT) begin
            state_q     <= S_WRITE;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merge_d;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
        end
      endcase
    end
  end

  assign MEM_ADDR  = mem_addr_q;
  assign MEM_RD    = mem_rd_q;
  assign MEM_WR    = mem_wr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit. Two instances run side by side, one with
// a read latency of 1 and one with 3, both fed the same requests. Each
// instance has its own memory responder and its own scoreboard queue.
module tb_store_merge_unit;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    int          rdCycle;
    int          wrCycle;
    int          doneCycle;
    logic        misalign;
  } expT;

  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  storeType;
  logic [63:0] addr;
  logic [63:0] storeData;

  logic [63:0] memAddr  [2];
  logic        memRd    [2];
  logic        memWr    [2];
  logic [63:0] memWdata [2];
  logic [63:0] memRdata [2];
  logic        busy     [2];
  logic        done     [2];
  logic        misalign [2];

  logic [4:0]  rdHist0 = '0;
  logic [4:0]  rdHist1 = '0;

  int          cyc = 0;
  int          checksTotal = 0;
  int          checksPassed = 0;
  expT         expQ [2][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  store_merge_unit #(.MEM_RD_LAT(1)) dutLat1 (
    .clk(clk), .reset(reset), .START(start), .STORE_TYPE(storeType),
    .ADDR(addr), .STORE_DATA(storeData), .MEM_ADDR(memAddr[0]),
    .MEM_RD(memRd[0]), .MEM_WR(memWr[0]), .MEM_WDATA(memWdata[0]),
    .MEM_RDATA(memRdata[0]), .BUSY(busy[0]), .DONE(done[0]),
    .MISALIGN(misalign[0])
  );

  store_merge_unit #(.MEM_RD_LAT(3)) dutLat3 (
    .clk(clk), .reset(reset), .START(start), .STORE_TYPE(storeType),
    .ADDR(addr), .STORE_DATA(storeData), .MEM_ADDR(memAddr[1]),
    .MEM_RD(memRd[1]), .MEM_WR(memWr[1]), .MEM_WDATA(memWdata[1]),
    .MEM_RDATA(memRdata[1]), .BUSY(busy[1]), .DONE(done[1]),
    .MISALIGN(misalign[1])
  );

  // Fixed memory image: 0x100 holds the reference pattern, every other
  // doubleword is derived from its address.
  function automatic logic [63:0] memModel(input logic [63:0] a);
    if (a == 64'h100) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // Read responder: data is valid only in the cycle exactly latency
  // cycles after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    rdHist0 <= {rdHist0[3:0], memRd[0]};
    rdHist1 <= {rdHist1[3:0], memRd[1]};
  end

  assign memRdata[0] = rdHist0[0] ? memModel(memAddr[0]) : GARBAGE;
  assign memRdata[1] = rdHist1[2] ? memModel(memAddr[1]) : GARBAGE;

  // Byte-wise reference merge with natural alignment by truncation.
  function automatic logic [63:0] modelMerge(input logic [63:0] old,
                                             input logic [63:0] data,
                                             input logic [1:0]  t,
                                             input logic [63:0] a);
    int width = 1 << t;
    int off = (int'(a[2:0]) / width) * width;
    logic [63:0] r = old;
    for (int i = 0; i < width; i++) r[(off + i)*8 +: 8] = data[i*8 +: 8];
    return r;
  endfunction

  function automatic bit isMisaligned(input logic [1:0] t, input logic [63:0] a);
    int width = 1 << t;
    return (int'(a[2:0]) % width) != 0;
  endfunction

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checksTotal++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    else
      checksPassed++;
  endtask

  // Drives one START pulse and pushes the expected memory activity and
  // timing for both instances. Returns one cycle after acceptance.
  task automatic applyStimulus(input logic [1:0] t, input logic [63:0] a,
                               input logic [63:0] d);
    expT e;
    int  n;
    bit  trap;
    @(posedge clk);
    #1;
    start     = 1'b1;
    storeType = t;
    addr      = a;
    storeData = d;
    n         = cyc;
`ifdef STORE_MISALIGN_TRAP_EN
    trap = isMisaligned(t, a);
`else
    trap = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      int lat = (k == 0) ? 1 : 3;
      e.addr     = {a[63:3], 3'b000};
      e.misalign = trap;
      if (trap) begin
        e.wdata     = '0;
        e.rdCycle   = -1;
        e.wrCycle   = -1;
        e.doneCycle = n + 1;
      end else if (t == 2'b11) begin
        e.wdata     = d;
        e.rdCycle   = -1;
        e.wrCycle   = n + 1;
        e.doneCycle = n + 2;
      end else begin
        e.wdata     = modelMerge(memModel(e.addr), d, t, a);
        e.rdCycle   = n + 1;
        e.wrCycle   = n + 2 + lat;
        e.doneCycle = n + 3 + lat;
      end
      expQ[k].push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits, with a bounded cycle budget, until both scoreboards drain.
  task automatic waitIdle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (expQ[0].size() == 0 && expQ[1].size() == 0) break;
      @(posedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.drained[%0d]", tag, k), 64'(expQ[k].size()), 64'd0);
      expQ[k].delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.memAddr[%0d]", tag, k), memAddr[k], 64'd0);
      checkOutput($sformatf("%s.memRd[%0d]", tag, k), 64'(memRd[k]), 64'd0);
      checkOutput($sformatf("%s.memWr[%0d]", tag, k), 64'(memWr[k]), 64'd0);
      checkOutput($sformatf("%s.memWdata[%0d]", tag, k), memWdata[k], 64'd0);
      checkOutput($sformatf("%s.busy[%0d]", tag, k), 64'(busy[k]), 64'd0);
      checkOutput($sformatf("%s.done[%0d]", tag, k), 64'(done[k]), 64'd0);
      checkOutput($sformatf("%s.misalign[%0d]", tag, k), 64'(misalign[k]), 64'd0);
    end
  endtask

  // Monitor on the falling edge: every strobe is matched against the head
  // of that instance's scoreboard, and the idle-value rules are checked.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rdWrExclusive[%0d]", k), 64'(memRd[k] & memWr[k]), 64'd0);
      if (!memWr[k])
        checkOutput($sformatf("wdataIdle[%0d]", k), memWdata[k], 64'd0);
      if (!busy[k])
        checkOutput($sformatf("addrIdle[%0d]", k), memAddr[k], 64'd0);
      if (memRd[k] || memWr[k] || done[k]) begin
        if (expQ[k].size() == 0) begin
          checkOutput($sformatf("unexpectedStrobe[%0d]", k),
                      {61'd0, memRd[k], memWr[k], done[k]}, 64'd0);
        end else begin
          if (memRd[k]) begin
            checkOutput($sformatf("rdCycle[%0d]", k), 64'(cyc), 64'(expQ[k][0].rdCycle));
            checkOutput($sformatf("rdAddr[%0d]", k), memAddr[k], expQ[k][0].addr);
          end
          if (memWr[k]) begin
            checkOutput($sformatf("wrCycle[%0d]", k), 64'(cyc), 64'(expQ[k][0].wrCycle));
            checkOutput($sformatf("wrAddr[%0d]", k), memAddr[k], expQ[k][0].addr);
            checkOutput($sformatf("wrData[%0d]", k), memWdata[k], expQ[k][0].wdata);
          end
          if (done[k]) begin
            checkOutput($sformatf("doneCycle[%0d]", k), 64'(cyc), 64'(expQ[k][0].doneCycle));
            checkOutput($sformatf("doneMisalign[%0d]", k), 64'(misalign[k]),
                        64'(expQ[k][0].misalign));
            checkOutput($sformatf("doneBusy[%0d]", k), 64'(busy[k]), 64'd1);
            void'(expQ[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    storeType = 2'b00;
    addr      = '0;
    storeData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    applyStimulus(2'b00, 64'h103, 64'h0000_0000_0000_00AB);
    waitIdle("sb");
    applyStimulus(2'b01, 64'h106, 64'h0000_0000_FFFF_BEEF);
    waitIdle("sh");
    applyStimulus(2'b10, 64'h104, 64'h0000_0000_DEAD_BEEF);
    waitIdle("sw");

    // sd, with a second START while busy that must be ignored.
    applyStimulus(2'b11, 64'h108, 64'hCAFE_F00D_1234_5678);
    start     = 1'b1;
    storeType = 2'b00;
    addr      = 64'h200;
    storeData = 64'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle("sdIgnoreStart");

    // Misaligned cases: trap when enabled, truncation otherwise.
    applyStimulus(2'b10, 64'h102, 64'h0000_0000_DEAD_BEEF);
    waitIdle("swMis");
    applyStimulus(2'b01, 64'h101, 64'h0000_0000_0000_1234);
    waitIdle("shMis");
    applyStimulus(2'b11, 64'h10D, 64'h0123_4567_89AB_CDEF);
    waitIdle("sdMis");
    applyStimulus(2'b00, 64'h107, 64'hFFFF_FFFF_FFFF_FF5C);
    waitIdle("sbTop");

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  t = 2'($urandom_range(0, 3));
      logic [63:0] a = 64'($urandom_range(0, 4095));
      logic [63:0] d = {$urandom, $urandom};
      applyStimulus(t, a, d);
      waitIdle($sformatf("rand%0d", i));
    end

    // Reset during WAIT of an sb: nothing may be written afterwards.
    applyStimulus(2'b00, 64'h103, 64'h0000_0000_0000_00AB);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("resetInWait");
    expQ[0].delete();
    expQ[1].delete();
    reset = 1'b0;
    repeat (8) @(posedge clk);
    applyStimulus(2'b00, 64'h103, 64'h0000_0000_0000_00AB);
    waitIdle("sbAfterReset");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
